// File: rtl/move_submitter_pkg.sv
// Shared board definitions for the move submitter: cell/index types, FSM states
// and board lookup helpers.
package move_submitter_pkg;

  localparam int BOARD_ROWS  = 3;
  localparam int BOARD_COLS  = 3;
  localparam int BOARD_CELLS = 9;

  typedef logic [1:0] STATE_T;
  typedef logic [3:0] INDEX_T;
  typedef logic       FLAG_T;

  localparam STATE_T CELL_BLANK  = 2'b00;
  localparam FLAG_T  TURN_PLAYER = 1'b0;
  localparam INDEX_T LOC_NONE    = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SETUP,
    S_ASSERT,
    S_RELEASE,
    S_CONFIRM
  } fsm_state_e;

  function automatic STATE_T cell_at(input logic [2*BOARD_CELLS-1:0] brd, input INDEX_T idx);
    STATE_T c;
    c = CELL_BLANK;
    for (int i = 0; i < BOARD_CELLS; i++) begin
      if (idx == INDEX_T'(i)) c = brd[2*i +: 2];
    end
    return c;
  endfunction

  // CPU preference: centre first, then the remaining cells in index order.
  function automatic INDEX_T scan_order(input INDEX_T step);
    if (step == '0) return INDEX_T'(BOARD_CELLS / 2);
    else if (step <= INDEX_T'(BOARD_CELLS / 2)) return step - INDEX_T'(1);
    else return step;
  endfunction

endpackage

// File: rtl/move_submitter_if.sv
// Board write bus: the submitter (master) presents loc/val/submit/board_reset,
// the board (slave) returns its cell contents and turn flag.
interface move_submitter_if;
  import move_submitter_pkg::*;

  INDEX_T                   update_loc;
  STATE_T                   update_val;
  logic                     submit;
  logic                     board_reset;
  FLAG_T                    turn;
  logic [2*BOARD_CELLS-1:0] board;

  modport master (
    output update_loc, update_val, submit, board_reset,
    input  turn, board
  );

  modport slave (
    input  update_loc, update_val, submit, board_reset,
    output turn, board
  );
endinterface

// File: rtl/move_submitter_cursor_nav.sv
// Cursor register with wrapping row/column navigation; one direction applied
// per cycle with priority up > down > left > right.
module move_submitter_cursor_nav
  import move_submitter_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   btn_up,
  input  logic   btn_down,
  input  logic   btn_left,
  input  logic   btn_right,
  output INDEX_T cursor
);

  localparam logic [1:0] LAST_ROW = 2'(BOARD_ROWS - 1);
  localparam logic [1:0] LAST_COL = 2'(BOARD_COLS - 1);

  logic [1:0] row_q;
  logic [1:0] col_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= 2'd1;
      col_q <= 2'd1;
    end else if (btn_up) begin
      row_q <= (row_q == 2'd0) ? LAST_ROW : row_q - 2'd1;
    end else if (btn_down) begin
      row_q <= (row_q == LAST_ROW) ? 2'd0 : row_q + 2'd1;
    end else if (btn_left) begin
      col_q <= (col_q == 2'd0) ? LAST_COL : col_q - 2'd1;
    end else if (btn_right) begin
      col_q <= (col_q == LAST_COL) ? 2'd0 : col_q + 2'd1;
    end
  end

  assign cursor = INDEX_T'(row_q) * INDEX_T'(BOARD_COLS) + INDEX_T'(col_q);

endmodule

// File: rtl/move_submitter.sv
// Board write initiator: turns player selections and CPU scans into
// setup/assert/release submit handshakes and confirms them via the turn flag.
module move_submitter
  import move_submitter_pkg::*;
#(
  parameter int     SUBMIT_HIGH     = 2,
  parameter int     CONFIRM_TIMEOUT = 8,
  parameter STATE_T PLAYER_VAL      = 2'b01,
  parameter STATE_T CPU_VAL         = 2'b10
) (
  input  logic             clk,
  input  logic             reset,
  move_submitter_if.master bus,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_sel,
  input  logic             new_game,
  input  logic             cpu_en,
  output INDEX_T           cursor,
  output logic             busy,
  output logic             done,
  output logic             reject,
  output logic             board_full,
  output logic             timeout_err
);

  localparam int CNT_W = 8;

  fsm_state_e       state_q;
  INDEX_T           loc_q;
  INDEX_T           scan_q;
  STATE_T           val_q;
  logic             submit_q;
  logic             brst_q;
  logic             clear_q;
  FLAG_T            turn_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             reject_q;
  logic             full_q;
  logic             tmo_q;

  INDEX_T           probe_d;
  logic             sel_ok_d;

  move_submitter_cursor_nav u_nav (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .cursor    (cursor)
  );

  assign probe_d  = scan_order(scan_q);
  assign sel_ok_d = (bus.turn == TURN_PLAYER) && (cell_at(bus.board, cursor) == CELL_BLANK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      loc_q    <= LOC_NONE;
      val_q    <= CELL_BLANK;
      submit_q <= 1'b0;
      brst_q   <= 1'b0;
      clear_q  <= 1'b0;
      cnt_q    <= '0;
      scan_q   <= '0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      full_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      full_q   <= 1'b0;
      tmo_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (new_game) begin
            state_q <= S_SETUP;
            loc_q   <= LOC_NONE;
            val_q   <= CELL_BLANK;
            brst_q  <= 1'b1;
            clear_q <= 1'b1;
          end else if (btn_sel) begin
            if (!sel_ok_d) begin
              reject_q <= 1'b1;
            end else begin
              state_q <= S_SETUP;
              loc_q   <= cursor;
              val_q   <= PLAYER_VAL;
              brst_q  <= 1'b0;
              clear_q <= 1'b0;
            end
          end else if (cpu_en && bus.turn != TURN_PLAYER) begin
            state_q <= S_SCAN;
            scan_q  <= '0;
          end
        end
        S_SCAN: begin
          if (new_game) begin
            state_q <= S_SETUP;
            loc_q   <= LOC_NONE;
            val_q   <= CELL_BLANK;
            brst_q  <= 1'b1;
            clear_q <= 1'b1;
          end else if (cell_at(bus.board, probe_d) == CELL_BLANK) begin
            state_q <= S_SETUP;
            loc_q   <= probe_d;
            val_q   <= CPU_VAL;
            brst_q  <= 1'b0;
            clear_q <= 1'b0;
          end else if (scan_q == INDEX_T'(BOARD_CELLS - 1)) begin
            full_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            scan_q <= scan_q + INDEX_T'(1);
          end
        end
        S_SETUP: begin
          turn_q   <= bus.turn;
          submit_q <= 1'b1;
          cnt_q    <= '0;
          state_q  <= S_ASSERT;
        end
        S_ASSERT: begin
          // cnt_q restarts at 1 on the release edge so it counts cycles since submit fell.
          if (cnt_q >= CNT_W'(SUBMIT_HIGH - 1)) begin
            submit_q <= 1'b0;
            cnt_q    <= CNT_W'(1);
            state_q  <= S_RELEASE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (clear_q) begin
            brst_q  <= 1'b0;
            clear_q <= 1'b0;
            loc_q   <= LOC_NONE;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= S_CONFIRM;
          end
        end
        S_CONFIRM: begin
          if (bus.turn != turn_q) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (cnt_q >= CNT_W'(CONFIRM_TIMEOUT)) begin
            tmo_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.update_loc  = loc_q;
  assign bus.update_val  = val_q;
  assign bus.submit      = submit_q;
  assign bus.board_reset = brst_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign reject          = reject_q;
  assign board_full      = full_q;
  assign timeout_err     = tmo_q;

endmodule

// File: tb/tb_move_submitter.sv
// Directed-plus-random bench for move_submitter with a behavioural board that
// commits one cycle after submit falls and toggles turn on accepted moves.
module tb_move_submitter;
  import move_submitter_pkg::*;

  localparam int         SUBMIT_HIGH     = 2;
  localparam int         CONFIRM_TIMEOUT = 8;
  localparam logic [1:0] PLAYER_VAL      = 2'b01;
  localparam logic [1:0] CPU_VAL         = 2'b10;

  logic clk, reset;
  logic btn_up, btn_down, btn_left, btn_right, btn_sel, new_game, cpu_en;
  logic [3:0] cursor;
  logic busy, done, reject, board_full, timeout_err;

  logic [1:0]  cells [9];
  logic [17:0] brd;
  logic        trn;
  bit          toggle_en, pend, sub_prev, cap_brst;
  logic [3:0]  cap_loc;
  logic [1:0]  cap_val;
  int          crow, ccol;
  int          checks, failures;
  int          order [9] = '{4, 0, 1, 2, 3, 5, 6, 7, 8};

  move_submitter_if bus ();

  assign bus.turn  = trn;
  assign bus.board = brd;

  always_comb begin
    brd = '0;
    for (int i = 0; i < 9; i++) brd[2*i +: 2] = cells[i];
  end

  move_submitter #(
    .SUBMIT_HIGH     (SUBMIT_HIGH),
    .CONFIRM_TIMEOUT (CONFIRM_TIMEOUT),
    .PLAYER_VAL      (PLAYER_VAL),
    .CPU_VAL         (CPU_VAL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_sel     (btn_sel),
    .new_game    (new_game),
    .cpu_en      (cpu_en),
    .cursor      (cursor),
    .busy        (busy),
    .done        (done),
    .reject      (reject),
    .board_full  (board_full),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and let the board model react to the submit waveform.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pend) begin
      if (cap_brst) begin
        for (int i = 0; i < 9; i++) cells[i] = 2'b00;
      end else if (toggle_en && int'(cap_loc) < 9) begin
        cells[int'(cap_loc)] = cap_val;
        trn = ~trn;
      end
      pend = 1'b0;
    end
    if (sub_prev && !bus.submit) pend = 1'b1;
    if (bus.submit) begin
      cap_loc  = bus.update_loc;
      cap_val  = bus.update_val;
      cap_brst = bus.board_reset;
    end
    sub_prev = bus.submit;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cursor"}, cursor, 4);
    chk({tag, "_loc"}, bus.update_loc, 4'hF);
    chk({tag, "_val"}, bus.update_val, 2'b00);
    chk({tag, "_submit"}, bus.submit, 0);
    chk({tag, "_brst"}, bus.board_reset, 0);
    chk({tag, "_flags"}, {busy, done, reject, board_full, timeout_err}, 0);
  endtask

  task automatic press(input bit u, input bit d, input bit l, input bit r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    tick();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    if (u)      crow = (crow + 2) % 3;
    else if (d) crow = (crow + 1) % 3;
    else if (l) ccol = (ccol + 2) % 3;
    else if (r) ccol = (ccol + 1) % 3;
    chk("cursor", cursor, crow * 3 + ccol);
  endtask

  task automatic goto_cell(input int t);
    while (crow != t / 3) press(0, 1, 0, 0);
    while (ccol != t % 3) press(0, 0, 0, 1);
  endtask

  task automatic reject_step(input string tag);
    btn_sel = 1;
    tick();
    btn_sel = 0;
    chk({tag, "_rej"}, reject, 1);
    chk({tag, "_sub"}, bus.submit, 0);
    tick();
    chk({tag, "_rej1"}, reject, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Trigger inputs must already be set; they are dropped after the first edge.
  task automatic handshake(input string tag, input int exp_rise, input logic [3:0] eloc,
                           input logic [1:0] eval, input bit ebrst, input bit exp_tmo,
                           input int exp_end);
    int n, h, m;
    n = 0;
    do begin
      tick();
      n++;
      btn_sel  = 0;
      new_game = 0;
    end while (!bus.submit && n < 40);
    chk({tag, "_rise"}, n, exp_rise);
    h = 0;
    while (bus.submit && h < 20) begin
      chk({tag, "_loc"}, bus.update_loc, eloc);
      chk({tag, "_val"}, bus.update_val, eval);
      chk({tag, "_brst"}, bus.board_reset, ebrst);
      btn_sel = (h == 0);
      tick();
      h++;
      chk({tag, "_busyrej"}, reject, 0);
    end
    btn_sel = 0;
    chk({tag, "_high"}, h, SUBMIT_HIGH);
    chk({tag, "_relloc"}, bus.update_loc, eloc);
    chk({tag, "_relbrst"}, bus.board_reset, ebrst);
    m = 0;
    do begin
      tick();
      m++;
    end while (!done && !timeout_err && m < 30);
    chk({tag, "_end"}, m, exp_end);
    chk({tag, "_done"}, done, !exp_tmo);
    chk({tag, "_tmo"}, timeout_err, exp_tmo);
    tick();
    chk({tag, "_pulse"}, {done, timeout_err}, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int n, p, cur;
    bit saw_sub, accept;
    logic [3:0] b;
    checks = 0; failures = 0;
    reset = 1; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    btn_sel = 0; new_game = 0; cpu_en = 0;
    trn = TURN_PLAYER; toggle_en = 1; pend = 0; sub_prev = 0; cap_brst = 0;
    cap_loc = '0; cap_val = '0;
    for (int i = 0; i < 9; i++) cells[i] = 2'b00;
    tick();
    tick();
    chk_reset("rst");
    reset = 0; crow = 1; ccol = 1;

    press(0, 0, 0, 1);
    press(0, 0, 0, 1);
    press(0, 1, 0, 0);
    repeat (16) begin
      b = 4'($urandom_range(0, 15));
      press(b[3], b[2], b[1], b[0]);
    end

    goto_cell(4);
    btn_sel = 1;
    handshake("p4", 2, 4'd4, PLAYER_VAL, 0, 0, 2);

    trn = TURN_PLAYER;
    reject_step("occ");
    goto_cell(0);
    trn = ~TURN_PLAYER;
    reject_step("cputurn");

    for (int i = 0; i < 9; i++) cells[i] = 2'b00;
    cells[4] = 2'b01; cells[0] = 2'b10; cells[1] = 2'b01;
    trn = ~TURN_PLAYER; cpu_en = 1;
    handshake("cpu", 6, 4'd2, CPU_VAL, 0, 0, 2);
    cpu_en = 0;

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 9; i++) cells[i] = 2'($urandom_range(1, 2));
      for (int i = 0; i < 9; i++) if ($urandom_range(0, 3) == 0) cells[i] = 2'b00;
      cells[order[$urandom_range(0, 8)]] = 2'b00;
      p = 0;
      while (cells[order[p]] != 2'b00) p++;
      trn = ~TURN_PLAYER; cpu_en = 1;
      handshake("cpurnd", p + 3, 4'(order[p]), CPU_VAL, 0, 0, 2);
      cpu_en = 0;
    end

    for (int i = 0; i < 9; i++) cells[i] = 2'b01;
    trn = ~TURN_PLAYER; cpu_en = 1;
    n = 0; saw_sub = 0;
    do begin
      tick();
      n++;
      if (bus.submit) saw_sub = 1;
    end while (!board_full && n < 30);
    cpu_en = 0;
    chk("full_lat", n, 10);
    chk("full_nosub", saw_sub, 0);
    tick();
    chk("full_pulse", board_full, 0);
    chk("full_idle", busy, 0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 9; i++) cells[i] = 2'($urandom_range(0, 2));
      trn = 1'($urandom_range(0, 1));
      cur = $urandom_range(0, 8);
      goto_cell(cur);
      accept = (trn == TURN_PLAYER) && (cells[cur] == 2'b00);
      if (accept) begin
        btn_sel = 1;
        handshake("prnd", 2, 4'(cur), PLAYER_VAL, 0, 0, 2);
      end else begin
        reject_step("prnd");
      end
    end

    for (int i = 0; i < 9; i++) cells[i] = 2'b00;
    trn = TURN_PLAYER; toggle_en = 0;
    goto_cell(8);
    btn_sel = 1;
    handshake("tmo", 2, 4'd8, PLAYER_VAL, 0, 1, CONFIRM_TIMEOUT);
    toggle_en = 1;

    new_game = 1;
    handshake("clr", 2, 4'hF, 2'b00, 1, 0, 1);
    chk("clr_loc", bus.update_loc, 4'hF);
    chk("clr_brst", bus.board_reset, 0);

    for (int i = 0; i < 9; i++) cells[i] = 2'b10;
    trn = ~TURN_PLAYER; cpu_en = 1;
    tick();
    cpu_en = 0;
    chk("ngscan_busy", busy, 1);
    new_game = 1;
    handshake("ngscan", 2, 4'hF, 2'b00, 1, 0, 1);

    for (int i = 0; i < 9; i++) cells[i] = 2'b00;
    trn = TURN_PLAYER; toggle_en = 0;
    goto_cell(7);
    btn_sel = 1;
    tick();
    btn_sel = 0;
    tick();
    chk("mid_sub", bus.submit, 1);
    reset = 1;
    tick();
    chk_reset("mid");
    reset = 0; crow = 1; ccol = 1;
    tick();
    chk("mid_idle", busy, 0);
    toggle_en = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_submitter.md
Name: move_submitter

Overview:
- Initiator side of the board write interface (update_loc / update_val / submit / board reset / turn).
- Turns player cursor and select pulses into board move submissions.
- Generates the CPU opponent's move by scanning the board for a blank cell.
- Drives the submit pulse with defined setup, high and release phases. Confirms acceptance by watching turn toggle, and flags rejects and timeouts.

Parameters:
- SUBMIT_HIGH, 2, cycles submit is held high; min 1.
- CONFIRM_TIMEOUT, 8, cycles after submit falls to wait for a turn toggle before timeout_err.
- PLAYER_VAL, 2'b01, cell value written for player moves; must not equal CELL_BLANK.
- CPU_VAL, 2'b10, cell value written for CPU moves; must not equal CELL_BLANK or PLAYER_VAL.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- turn  in  1  board turn flag; TURN_PLAYER means player to move, otherwise CPU.
- board  in  18  9 cells x 2 bits, row-major, cell i at bits [2i+1:2i].
- btn_up, btn_down, btn_left, btn_right  in  1 each  single-cycle cursor pulses.
- btn_sel  in  1  single-cycle request to play the cursor cell.
- new_game  in  1  single-cycle request to clear the board.
- cpu_en  in  1  enables automatic CPU moves.
- cursor  out  4  current cursor index, 0..8.
- update_loc  out  4  index presented to the board.
- update_val  out  2  value presented to the board.
- submit  out  1  board commit strobe; the board commits on the falling edge.
- board_reset  out  1  board clear request, valid while submit is high.
- busy  out  1  high in any state other than IDLE.
- done  out  1  1-cycle pulse when a move is confirmed or a clear completes.
- reject  out  1  1-cycle pulse when btn_sel is refused.
- board_full  out  1  1-cycle pulse when a CPU scan finds no blank cell.
- timeout_err  out  1  1-cycle pulse when a move is not confirmed.

Behaviour:
- Reset values:
  - state=IDLE, cursor=4.
  - update_loc=4'hF, update_val=CELL_BLANK.
  - submit, board_reset, busy, done, reject, board_full, timeout_err all 0.
- Cursor:
  - Index is row*3+col; updated the cycle after a button pulse, in any state.
  - Up/down wrap rows 0<->2; left/right wrap columns within the current row (e.g. 3 left -> 5).
  - Simultaneous direction pulses: priority up > down > left > right; only one applied.
- FSM states: IDLE, SCAN, SETUP, ASSERT, RELEASE, CONFIRM.
- IDLE priority order:
  1. new_game -> SETUP with update_loc=4'hF, board_reset=1, clear=1.
  2. btn_sel -> reject pulse next cycle, stay IDLE, if turn!=TURN_PLAYER or board[cursor]!=CELL_BLANK. Otherwise SETUP with update_loc=cursor, update_val=PLAYER_VAL.
  3. cpu_en && turn!=TURN_PLAYER -> SCAN.
- btn_sel or new_game while busy: ignored, no reject pulse.
- SCAN:
  - Probe order: 4,0,1,2,3,5,6,7,8, one cell per cycle.
  - First blank cell -> SETUP with update_val=CPU_VAL.
  - All 9 non-blank -> board_full pulse, return to IDLE.
  - new_game during SCAN aborts the scan and goes to the clear SETUP.
- SETUP: 1 cycle; submit=0, loc/val/board_reset stable; snapshot turn into turn_q.
- ASSERT: submit=1 for exactly SUBMIT_HIGH cycles; loc/val/board_reset held.
- RELEASE: 1 cycle; submit=0 (the board commits on this edge); loc/val still held.
- After RELEASE:
  - Clear: board_reset=0, update_loc=4'hF, done pulse, IDLE; no confirm because the board does not toggle turn.
  - Move: go to CONFIRM.
- CONFIRM:
  - turn!=turn_q -> done pulse, IDLE.
  - After CONFIRM_TIMEOUT cycles with no toggle -> timeout_err pulse, IDLE.
- update_loc/update_val never change while submit=1.
- Latency: player move from btn_sel to submit rising = 2 cycles (decide + SETUP).
- Reset mid-handshake:
  - All outputs go to reset values on the next edge.
  - A submit falling edge caused by reset is a system-level hazard. Top level must reset the board alongside this block.
  - The bench checks only this block's outputs.

Decomposition:
- Shared defines file, existing:
  - BOARD_ROWS=3, BOARD_COLS=3.
  - STATE_T width 2, CELL_BLANK=0, INDEX_T width 4, FLAG_T width 1, TURN_PLAYER.
- Shared defines file, add:
  - BOARD_CELLS=9.
  - LOC_NONE=4'hF.
  - FSM state encodings.
- Sub-module cursor_nav: cursor register, button priority and wrap logic; outputs cursor.

Test Plan:
- Reset, then btn_right x2, btn_down -> cursor 4->5->3->6.
- Player turn, blank board, cursor=4, btn_sel, board model toggles turn on the falling edge:
  - submit rises 2 cycles after sel, high 2 cycles.
  - update_loc=4, update_val=01 stable throughout.
  - done pulses 1 cycle after turn toggles.
- btn_sel on occupied cell 4 -> reject pulses 1 cycle, submit stays 0.
- btn_sel while turn is CPU -> reject pulses 1 cycle, submit stays 0.
- cpu_en=1, turn=CPU, cells 4,0,1 occupied -> CPU submit with update_loc=2, update_val=10.
- cpu_en=1, turn=CPU, all 9 cells occupied -> board_full pulses 1 cycle, no submit.
- Player move with the board model never toggling turn -> timeout_err pulses 8 cycles after submit falls.
- new_game -> submit pulse with board_reset=1, update_loc=F, done pulses after RELEASE.
